// File: rtl/bist_session_scheduler.sv
// bist_session_scheduler: runs BIST on each enabled core in ascending order over a
// shared PRPG/MISR, then reports per-core pass / fail / timeout results.
// Pulses and status outputs are registered decodes of the current state, so they
// appear one cycle after the state that produces them.
module bist_session_scheduler #(
    parameter int NUM_CUT = 4,
    parameter int SIG_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rstIn,
    input  logic                     start,
    input  logic [NUM_CUT-1:0]       cut_mask,
    input  logic [NUM_CUT*SIG_W-1:0] golden_sig,
    input  logic [SIG_W-1:0]         misr_sig,
    input  logic [NUM_CUT-1:0]       bist_done,
    output logic                     shared_rst,
    output logic [NUM_CUT-1:0]       bist_start,
    output logic [3:0]               cur_cut,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_CUT-1:0]       pass_vec,
    output logic [NUM_CUT-1:0]       fail_vec,
    output logic [NUM_CUT-1:0]       tmo_vec
);

    // One extra bit so the pointer can sit one past the last core.
    localparam int PTR_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_CLEAR,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [NUM_CUT-1:0] mask_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [15:0]        wd_q;

    logic               found;
    logic [3:0]         found_idx;
    logic [NUM_CUT-1:0] cur_sel;
    logic               cur_done;
    logic               timed_out;
    logic [SIG_W-1:0]   golden_cur;

    logic               shared_rst_d;
    logic [NUM_CUT-1:0] bist_start_d;
    logic               busy_d;
    logic               done_d;

    // Core lookup: lowest scheduled index at or above ptr, plus the serviced core's done and golden slice
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        found      = 1'b0;
        found_idx  = '0;
        cur_sel    = '0;
        golden_cur = '0;
        for (int i = NUM_CUT - 1; i >= 0; i--) begin
            if (mask_q[i] && (PTR_W'(i) >= ptr_q)) begin
                found     = 1'b1;
                found_idx = 4'(i);
            end
        end
        for (int i = 0; i < NUM_CUT; i++) begin
            if (cur_cut == 4'(i)) begin
                cur_sel[i] = 1'b1;
                golden_cur = golden_sig[i*SIG_W +: SIG_W];
            end
        end
        cur_done  = |(bist_done & cur_sel);
        timed_out = (wd_q == 16'(TIMEOUT));
    end

    // State register
    always_ff @(posedge clk or negedge rstIn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (!rstIn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; done wins over the watchdog when both land in the same WAIT cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FINISH: if (start) state_d = S_SELECT;
            S_SELECT:         state_d = found ? S_CLEAR : S_FINISH;
            S_CLEAR:          state_d = S_LAUNCH;
            S_LAUNCH:         state_d = S_WAIT;
            S_WAIT: begin
                if (cur_done) begin
                    state_d = S_CHECK;
                end else if (timed_out) begin
                    state_d = S_SELECT;
                end
            end
            S_CHECK:          state_d = S_SELECT;
            default:          state_d = S_IDLE;
        endcase
    end

    // Output decode from the current state, registered below
    always_comb begin
        shared_rst_d = (state_q == S_CLEAR);
        bist_start_d = (state_q == S_LAUNCH) ? cur_sel : '0;
        busy_d       = (state_q != S_IDLE) && (state_q != S_FINISH);
        done_d       = (state_q == S_FINISH);
    end

    // Output registers, run mask, pointer, watchdog and result vectors
    always_ff @(posedge clk or negedge rstIn) begin
        if (!rstIn) begin
            shared_rst <= 1'b0;
            bist_start <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cur_cut    <= '0;
            pass_vec   <= '0;
            fail_vec   <= '0;
            tmo_vec    <= '0;
            mask_q     <= '0;
            ptr_q      <= '0;
            wd_q       <= '0;
        end else begin
            shared_rst <= shared_rst_d;
            bist_start <= bist_start_d;
            busy       <= busy_d;
            done       <= done_d;
            case (state_q)
                S_IDLE, S_FINISH: begin
                    if (start) begin
                        mask_q   <= cut_mask;
                        ptr_q    <= '0;
                        pass_vec <= '0;
                        fail_vec <= '0;
                        tmo_vec  <= '0;
                    end
                end
                S_SELECT: begin
                    if (found) begin
                        cur_cut <= found_idx;
                        ptr_q   <= {1'b0, found_idx};
                    end
                end
                S_LAUNCH: wd_q <= '0;
                S_WAIT: begin
                    wd_q <= wd_q + 16'd1;
                    if (!cur_done && timed_out) begin
                        tmo_vec  <= tmo_vec | cur_sel;
                        fail_vec <= fail_vec | cur_sel;
                        ptr_q    <= {1'b0, cur_cut} + PTR_W'(1);
                    end
                end
                S_CHECK: begin
                    if (misr_sig == golden_cur) begin
                        pass_vec <= pass_vec | cur_sel;
                    end else begin
                        fail_vec <= fail_vec | cur_sel;
                    end
                    ptr_q <= {1'b0, cur_cut} + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bist_session_scheduler.md
Name: bist_session_scheduler

Overview:
- Runs BIST sessions on up to NUM_CUT circuits-under-test, one at a time, because the cores share one PRPG/MISR resource.
- For each enabled core, in ascending index order: clears the shared resource, launches that core's BIST controller, waits for its done, then compares the MISR signature against a golden value.
- Collects per-core pass/fail/timeout results for the top-level test access logic.

Parameters:
- NUM_CUT, 4, number of cores scheduled (1..16)
- SIG_W, 16, signature width in bits
- TIMEOUT, 1023, maximum cycles in WAIT before a core is declared hung (must be < 2^16)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rstIn  input  1  asynchronous, active-low reset
- start  input  1  level; sampled in IDLE/FINISH to begin a run
- cut_mask  input  NUM_CUT  bit i=1 schedules core i; captured when start is accepted
- golden_sig  input  NUM_CUT*SIG_W  golden signature of core i in bits [i*SIG_W +: SIG_W]
- misr_sig  input  SIG_W  signature from shared MISR
- bist_done  input  NUM_CUT  per-core done level from core BIST controllers
- shared_rst  output  1  one-cycle clear of shared PRPG/MISR
- bist_start  output  NUM_CUT  one-hot, one-cycle launch pulse
- cur_cut  output  4  index of the core being serviced
- busy  output  1  high from start acceptance until FINISH
- done  output  1  high in FINISH
- pass_vec  output  NUM_CUT  bit i=1: core i matched golden
- fail_vec  output  NUM_CUT  bit i=1: mismatch or timeout
- tmo_vec  output  NUM_CUT  bit i=1: core i timed out

Behaviour:
- Reset (rstIn=0, any state, immediate): state=IDLE; all outputs 0; internal mask, pointer and watchdog 0.
- States: IDLE, SELECT, CLEAR, LAUNCH, WAIT, CHECK, FINISH. Outputs are registered.
- IDLE: start=1 -> capture cut_mask, clear pass/fail/tmo vectors, ptr=0, busy=1, go to SELECT.
- SELECT: find the lowest i>=ptr with mask[i]=1.
  - Found: cur_cut=i, ptr=i, go to CLEAR.
  - None: go to FINISH.
- CLEAR: shared_rst=1 for exactly this one cycle -> LAUNCH.
- LAUNCH: bist_start[cur_cut]=1 for exactly this one cycle; watchdog=0 -> WAIT.
- WAIT: watchdog increments by 1 each cycle.
  - bist_done[cur_cut]=1 -> CHECK. Done takes priority if it arrives in the same cycle as timeout.
  - Otherwise, watchdog==TIMEOUT -> set tmo_vec[cur_cut] and fail_vec[cur_cut], ptr=cur_cut+1 -> SELECT.
  - bist_done bits of other cores are ignored.
- CHECK: misr_sig is sampled in this cycle. Equal to the golden slice -> set pass_vec[cur_cut]; else set fail_vec[cur_cut]. ptr=cur_cut+1 -> SELECT.
- ptr wrap: ptr is incremented after servicing index NUM_CUT-1, so SELECT finds no core and goes to FINISH. There is no wrap-around; each core runs at most once per run.
- FINISH: done=1, busy=0, result vectors held stable.
  - start=1 -> behaves exactly as IDLE acceptance and begins a new run (done drops the next cycle).
  - start=0 -> stays in FINISH.
- start while busy: ignored. cut_mask changes while busy: ignored.
- Result invariants: pass_vec & fail_vec == 0; tmo_vec is a subset of fail_vec; unscheduled cores read 0 in all three vectors.
- Latency for one core completing k cycles after launch: accept(1) + SELECT(1) + CLEAR(1) + LAUNCH(1) + WAIT(k) + CHECK(1), then SELECT(1) before the next core or FINISH.
- Empty mask: IDLE -> SELECT -> FINISH; done=1 on the 3rd rising edge after start is sampled.

Test Plan:
- Reset mid-run: deassert rstIn during WAIT -> all outputs 0 asynchronously, state IDLE; after release, start=1 runs normally.
- NUM_CUT=4, mask=4'b1011, each core asserts done 20 cycles after its launch, golden matches -> launch order 0,1,3 with a one-cycle shared_rst before each one-cycle bist_start; pass_vec=1011, fail_vec=0000, done=1.
- mask=4'b0110, core 2 signature = golden XOR 16'h0001 -> pass_vec=0010, fail_vec=0100, tmo_vec=0000.
- mask=4'b0001, core 0 never asserts done, TIMEOUT=1023 -> tmo_vec=0001, fail_vec=0001, done asserts after 1023 WAIT cycles plus overhead.
- bist_done[cur_cut] rises in the same cycle watchdog==TIMEOUT -> CHECK path taken, tmo bit stays 0.
- mask=0 -> done=1 on the 3rd edge after start; vectors all 0. In FINISH, start=1 with a new mask -> vectors cleared, new run begins, start pulses during busy have no effect.
